// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer
// Host-side SD CMD line sequencer. Serialises one 48-bit command frame
// with a CRC7 computed on the fly, then releases the line. If a response
// is expected, it waits for the card's start bit and deserialises a short
// (48-bit) or long (136-bit) response. It checks the response, inserts
// the NCC idle gap and pulses o_done.
// All line activity advances only on i_stb cycles (one per SD clock period).
module sd_cmd_sequencer #(
  parameter int RSP_TIMEOUT = 64,
  parameter int NCC_BITS    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_stb,
  input  logic         i_cmd_go,
  input  logic [5:0]   i_cmd_index,
  input  logic [31:0]  i_cmd_arg,
  input  logic [1:0]   i_rsp_type,
  input  logic         i_rsp_crc_en,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_rsp_timeout,
  output logic         o_crc_err,
  output logic [5:0]   o_rsp_index,
  output logic [127:0] o_rsp,
  output logic         o_sd_cmd_dir,
  output logic         o_sd_cmd_out,
  input  logic         i_sd_cmd_in
);

  // One shared strobe counter serves TX bit index, WAIT timeout,
  // RX bit count and NCC gap length.
  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] TX_CRC_FIRST  = CNT_W'(40);
  localparam logic [CNT_W-1:0] TX_END_BIT    = CNT_W'(47);
  localparam logic [CNT_W-1:0] TX_RELEASE    = CNT_W'(48);
  localparam logic [CNT_W-1:0] RX_CRC_LIMIT  = CNT_W'(40);
  localparam logic [CNT_W-1:0] RX_SHORT_LAST = CNT_W'(47);
  localparam logic [CNT_W-1:0] RX_LONG_LAST  = CNT_W'(135);
  localparam logic [CNT_W-1:0] WAIT_LAST     = CNT_W'(RSP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] NCC_LAST      = CNT_W'(NCC_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TX   = 3'd1,
    S_WAIT = 3'd2,
    S_RX   = 3'd3,
    S_NCC  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e state_q, state_d;

  // Transaction context latched at go acceptance
  logic             long_q,   long_d;
  logic             rsp_en_q, rsp_en_d;
  logic             crc_en_q, crc_en_d;

  // Serialiser / deserialiser state
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [39:0]      tx_sr_q,  tx_sr_d;
  logic [6:0]       crc_q,    crc_d;
  // Only the last 128 frame bits are ever reported (long payload is
  // bits [127:0], short fields lie in [47:0]). The older leading bits of a
  // 136-bit response are shifted out and never needed, so the register
  // stores 127 bits and the incoming bit completes the 128-bit view.
  logic [126:0]     rx_sr_q,  rx_sr_d;
  logic [127:0]     rx_full;
  logic             rx_last;

  // Registered line and status outputs
  logic             dir_q,     dir_d;
  logic             out_q,     out_d;
  logic             timeout_q, timeout_d;
  logic             crc_err_q, crc_err_d;
  logic [5:0]       idx_q,     idx_d;
  logic [127:0]     rsp_q,     rsp_d;

  // Serial CRC7, polynomial x^7 + x^3 + 1, one bit per call
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    crc7_step = {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

  assign rx_full = {rx_sr_q, i_sd_cmd_in};
  assign rx_last = long_q ? (cnt_q == RX_LONG_LAST) : (cnt_q == RX_SHORT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: every transition except go acceptance and DONE
  // is gated by the bit strobe
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_go) begin
          state_d = S_TX;
        end
      end
      S_TX: begin
        if (i_stb && (cnt_q == TX_RELEASE)) begin
          state_d = rsp_en_q ? S_WAIT : S_NCC;
        end
      end
      S_WAIT: begin
        if (i_stb) begin
          if (!i_sd_cmd_in) begin
            state_d = S_RX;
          end else if (cnt_q == WAIT_LAST) begin
            state_d = S_NCC;
          end
        end
      end
      S_RX: begin
        if (i_stb && rx_last) begin
          state_d = S_NCC;
        end
      end
      S_NCC: begin
        if (i_stb && (cnt_q == NCC_LAST)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded directly from the state register
  always_comb begin
    o_busy = (state_q != S_IDLE);
    o_done = (state_q == S_DONE);
  end

  // Datapath next-state: shifting, CRC, counters, line drive and status
  always_comb begin
    long_d    = long_q;
    rsp_en_d  = rsp_en_q;
    crc_en_d  = crc_en_q;
    cnt_d     = cnt_q;
    tx_sr_d   = tx_sr_q;
    crc_d     = crc_q;
    rx_sr_d   = rx_sr_q;
    dir_d     = dir_q;
    out_d     = out_q;
    timeout_d = timeout_q;
    crc_err_d = crc_err_q;
    idx_d     = idx_q;
    rsp_d     = rsp_q;

    case (state_q)
      S_IDLE: begin
        // A strobe coinciding with go does not shift; the first bit
        // goes out on the next strobe.
        if (i_cmd_go) begin
          tx_sr_d   = {2'b01, i_cmd_index, i_cmd_arg};
          crc_d     = 7'd0;
          cnt_d     = '0;
          long_d    = (i_rsp_type == 2'd2);
          rsp_en_d  = (i_rsp_type != 2'd0);
          crc_en_d  = i_rsp_crc_en;
          timeout_d = 1'b0;
          crc_err_d = 1'b0;
        end
      end

      S_TX: begin
        if (i_stb) begin
          if (cnt_q < TX_CRC_FIRST) begin
            // Start, transmission, index and argument bits feed the CRC
            out_d   = tx_sr_q[39];
            dir_d   = 1'b1;
            crc_d   = crc7_step(crc_q, tx_sr_q[39]);
            tx_sr_d = {tx_sr_q[38:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
          end else if (cnt_q < TX_END_BIT) begin
            // CRC7 shifted out MSB first
            out_d = crc_q[6];
            dir_d = 1'b1;
            crc_d = {crc_q[5:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
          end else if (cnt_q == TX_END_BIT) begin
            out_d = 1'b1;
            dir_d = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end else begin
            // Strobe after the end bit: release the line
            out_d = 1'b1;
            dir_d = 1'b0;
            cnt_d = '0;
          end
        end
      end

      S_WAIT: begin
        if (i_stb) begin
          if (!i_sd_cmd_in) begin
            // Start bit is bit 0 of the response; CRC of a lone zero
            // from a zero seed stays zero.
            rx_sr_d = '0;
            crc_d   = 7'd0;
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == WAIT_LAST) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_RX: begin
        if (i_stb) begin
          rx_sr_d = rx_full[126:0];
          if (cnt_q < RX_CRC_LIMIT) begin
            crc_d = crc7_step(crc_q, i_sd_cmd_in);
          end
          if (rx_last) begin
            cnt_d = '0;
            if (long_q) begin
              rsp_d     = rx_full;
              idx_d     = 6'd0;
              crc_err_d = ~rx_full[0];
            end else begin
              rsp_d     = {96'd0, rx_full[39:8]};
              idx_d     = rx_full[45:40];
              crc_err_d = crc_en_q && ((crc_q != rx_full[7:1]) || !rx_full[0]);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_NCC: begin
        if (i_stb) begin
          cnt_d = (cnt_q == NCC_LAST) ? '0 : cnt_q + 1'b1;
        end
      end

      default: begin
      end
    endcase
  end

  // Datapath registers; reset aborts any transaction and frees the line
  always_ff @(posedge clk) begin
    if (rst) begin
      long_q    <= 1'b0;
      rsp_en_q  <= 1'b0;
      crc_en_q  <= 1'b0;
      cnt_q     <= '0;
      tx_sr_q   <= '0;
      crc_q     <= 7'd0;
      rx_sr_q   <= '0;
      dir_q     <= 1'b0;
      out_q     <= 1'b1;
      timeout_q <= 1'b0;
      crc_err_q <= 1'b0;
      idx_q     <= 6'd0;
      rsp_q     <= '0;
    end else begin
      long_q    <= long_d;
      rsp_en_q  <= rsp_en_d;
      crc_en_q  <= crc_en_d;
      cnt_q     <= cnt_d;
      tx_sr_q   <= tx_sr_d;
      crc_q     <= crc_d;
      rx_sr_q   <= rx_sr_d;
      dir_q     <= dir_d;
      out_q     <= out_d;
      timeout_q <= timeout_d;
      crc_err_q <= crc_err_d;
      idx_q     <= idx_d;
      rsp_q     <= rsp_d;
    end
  end

  assign o_sd_cmd_dir  = dir_q;
  assign o_sd_cmd_out  = out_q;
  assign o_rsp_timeout = timeout_q;
  assign o_crc_err     = crc_err_q;
  assign o_rsp_index   = idx_q;
  assign o_rsp         = rsp_q;

endmodule
